ntt_scheduler: RTL and testbench

NTT_SCHEDULER -- requirements
Module: ntt_scheduler

---
 rtl/ntt_scheduler.sv | 176 +++++++++++++++++
 tb/tb_ntt_scheduler.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_scheduler.sv
// Address/twiddle sequencer for the Kyber 256-point NTT and inverse NTT.
// Emits one butterfly (or final scaling) command per handshake. All outputs are registered.
module ntt_scheduler #(
    parameter int N    = 256,
    parameter int LOGN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       inverse,
    output logic       bf_valid,
    input  logic       bf_ready,
    output logic [7:0] addr_a,
    output logic [7:0] addr_b,
    output logic [6:0] zeta_idx,
    output logic       scale,
    output logic [2:0] layer,
    output logic       busy,
    output logic       done
);
    localparam int            CW         = LOGN + 1;
    localparam logic [CW-1:0] SCALE_LAST = CW'(N - 1);
    localparam logic [6:0]    LAYER_LAST = 7'(N / 2 - 1);
    localparam logic [2:0]    LAST_LAYER = 3'(LOGN - 2);

    typedef enum logic [1:0] {IDLE, RUN, SCALE, DONE} state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] z;
    } cmd_t;

    state_t        state_q, state_d;
    logic          inv_q, inv_d;
    logic [2:0]    layer_q, layer_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    cmd_t          cmd_q, cmd_d;
    logic          bf_valid_q, bf_valid_d;
    logic          scale_q, scale_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          xfer;

    // Butterfly command for transfer c of layer lyr. Forward halves len each layer
    // with zetas counting up; inverse doubles len with zetas counting down.
    function automatic cmd_t bf_cmd(input logic inv, input logic [2:0] lyr, input logic [6:0] c);
        logic [7:0] len;
        logic [6:0] grp;
        logic [7:0] base;
        logic [7:0] off;
        cmd_t       r;
        if (!inv) begin
            len = 8'd128 >> lyr;
            grp = c >> (3'd7 - lyr);
        end else begin
            len = 8'd2 << lyr;
            grp = c >> (lyr + 3'd1);
        end
        base = ({1'b0, grp} * len) << 1;
        off  = {1'b0, c} & (len - 8'd1);
        r.a  = base + off;
        r.b  = r.a + len;
        r.z  = inv ? ((7'd127 >> lyr) - grp) : ((7'd1 << lyr) + grp);
        return r;
    endfunction

    assign xfer    = bf_valid_q & bf_ready;
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        inv_d      = inv_q;
        layer_d    = layer_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        bf_valid_d = bf_valid_q;
        scale_d    = scale_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    inv_d      = inverse;
                    layer_d    = 3'd0;
                    cnt_d      = '0;
                    cmd_d      = bf_cmd(inverse, 3'd0, 7'd0);
                    bf_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    scale_d    = 1'b0;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (cnt_q[6:0] != LAYER_LAST) begin
                        cnt_d = cnt_inc;
                        cmd_d = bf_cmd(inv_q, layer_q, cnt_inc[6:0]);
                    end else if (layer_q != LAST_LAYER) begin
                        layer_d = layer_q + 3'd1;
                        cnt_d   = '0;
                        cmd_d   = bf_cmd(inv_q, layer_q + 3'd1, 7'd0);
                    end else if (inv_q) begin
                        state_d = SCALE;
                        cnt_d   = '0;
                        cmd_d   = '0;
                        scale_d = 1'b1;
                    end else begin
                        state_d    = DONE;
                        cnt_d      = '0;
                        cmd_d      = '0;
                        bf_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            SCALE: begin
                // 9-bit counter so the terminal count 255 cannot alias the first command.
                if (xfer) begin
                    if (cnt_q == SCALE_LAST) begin
                        state_d    = DONE;
                        cnt_d      = '0;
                        cmd_d      = '0;
                        scale_d    = 1'b0;
                        bf_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                        cmd_d.a = cnt_inc[7:0];
                        cmd_d.b = 8'd0;
                        cmd_d.z = 7'd0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inv_q      <= 1'b0;
            layer_q    <= 3'd0;
            cnt_q      <= '0;
            cmd_q      <= '0;
            bf_valid_q <= 1'b0;
            scale_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inv_q      <= inv_d;
            layer_q    <= layer_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            bf_valid_q <= bf_valid_d;
            scale_q    <= scale_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bf_valid = bf_valid_q;
    assign addr_a   = cmd_q.a;
    assign addr_b   = cmd_q.b;
    assign zeta_idx = cmd_q.z;
    assign scale    = scale_q;
    assign layer    = layer_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ntt_scheduler.sv
// Randomized bench for ntt_scheduler; expected command streams come from a
// Kyber-style nested-loop reference of the forward and inverse transforms.
module tb_ntt_scheduler;
    typedef struct packed {
        logic [2:0] l;
        logic       s;
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] z;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       inverse = 1'b0;
    logic       bf_ready = 1'b0;
    logic       bf_valid;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic [6:0] zeta_idx;
    logic       scale;
    logic [2:0] layer;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    ntt_scheduler #(.N(256), .LOGN(8)) dut (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse),
        .bf_valid(bf_valid), .bf_ready(bf_ready),
        .addr_a(addr_a), .addr_b(addr_b), .zeta_idx(zeta_idx),
        .scale(scale), .layer(layer), .busy(busy), .done(done)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    cmd_t exp_q[$];
    cmd_t got_q[$];
    int   done_q[$];
    int   stall_bad;

    function automatic cmd_t mk(input int l, input int s, input int a, input int b, input int z);
        cmd_t r;
        r.l = 3'(l);
        r.s = 1'(s);
        r.a = 8'(a);
        r.b = 8'(b);
        r.z = 7'(z);
        return r;
    endfunction

    function automatic cmd_t cur();
        cmd_t r;
        r = {layer, scale, addr_a, addr_b, zeta_idx};
        return r;
    endfunction

    // Reference: the textbook Cooley-Tukey / Gentleman-Sande loop nests.
    function automatic void build_model(input bit inv);
        int k;
        int lyr;
        exp_q.delete();
        lyr = 0;
        if (!inv) begin
            k = 1;
            for (int len = 128; len >= 2; len = len / 2) begin
                for (int s = 0; s < 256; s += 2 * len) begin
                    for (int j = s; j < s + len; j++) exp_q.push_back(mk(lyr, 0, j, j + len, k));
                    k++;
                end
                lyr++;
            end
        end else begin
            k = 127;
            for (int len = 2; len <= 128; len = len * 2) begin
                for (int s = 0; s < 256; s += 2 * len) begin
                    for (int j = s; j < s + len; j++) exp_q.push_back(mk(lyr, 0, j, j + len, k));
                    k--;
                end
                lyr++;
            end
            for (int i = 0; i < 256; i++) exp_q.push_back(mk(6, 1, i, 0, 0));
        end
    endfunction

    // Starts a transform and records every transfer, done pulse and stall violation.
    task automatic drive(input bit inv, input int pct, input bit hold, input int poke_cyc,
                         input int abort_at, input int ndone, input int max_cyc);
        cmd_t snap;
        bit   snap_v;
        bit   stalled;
        int   cyc;
        got_q.delete();
        done_q.delete();
        stall_bad = 0;
        stalled   = 1'b0;
        snap      = '0;
        snap_v    = 1'b0;
        cyc       = 0;
        start     = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        inverse  = inv;
        start    = 1'b1;
        bf_ready = ($urandom_range(99) < pct);
        while (cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!hold) begin
                start   = 1'b0;
                inverse = 1'($urandom_range(1));
            end
            if (cyc == poke_cyc) begin
                start   = 1'b1;
                inverse = 1'b1;
            end
            if (done) done_q.push_back(cyc);
            if (stalled && (bf_valid !== snap_v || cur() !== snap)) stall_bad++;
            if (done_q.size() >= ndone) break;
            if (abort_at >= 0 && got_q.size() >= abort_at) break;
            bf_ready = ($urandom_range(99) < pct);
            stalled  = bf_valid && !bf_ready;
            snap     = cur();
            snap_v   = bf_valid;
            if (bf_valid && bf_ready) got_q.push_back(cur());
        end
        start    = 1'b0;
        bf_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [30:0] outs;
        int          act;
        #1 rst = 1'b1;
        #2;
        outs = {bf_valid, busy, done, scale, addr_a, addr_b, zeta_idx, layer};
        n_tests++;
        if (outs !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        act = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bf_valid || busy || done) act++;
        end
        n_tests++;
        if (act !== 0) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%0d active cycles exp=0", act);
        end
    endtask

    task automatic test_forward();
        int bad;
        build_model(1'b0);
        drive(1'b0, 100, 1'b0, -1, -1, 1, 3000);
        n_tests++;
        if ({bf_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_done_cycle_outputs got valid,busy=%b exp=00", {bf_valid, busy});
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({done, bf_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_done_one_cycle got done,valid=%b exp=00", {done, bf_valid});
        end
        n_tests++;
        if (got_q.size() !== 896) begin
            n_fail++;
            $display("FAIL fwd_count got=%0d exp=896", got_q.size());
        end
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL fwd_seq idx=%0d got=%h exp=%h", bad, got_q[bad], exp_q[bad]);
        end
        n_tests++;
        if (got_q[0] !== mk(0, 0, 0, 128, 1) || got_q[1] !== mk(0, 0, 1, 129, 1)) begin
            n_fail++;
            $display("FAIL fwd_first got=%h,%h exp=%h,%h", got_q[0], got_q[1],
                     mk(0, 0, 0, 128, 1), mk(0, 0, 1, 129, 1));
        end
        n_tests++;
        if (got_q[128] !== mk(1, 0, 0, 64, 2) || got_q[192] !== mk(1, 0, 128, 192, 3)) begin
            n_fail++;
            $display("FAIL fwd_layer1 got=%h,%h exp=%h,%h", got_q[128], got_q[192],
                     mk(1, 0, 0, 64, 2), mk(1, 0, 128, 192, 3));
        end
        n_tests++;
        if (got_q[895] !== mk(6, 0, 253, 255, 127)) begin
            n_fail++;
            $display("FAIL fwd_last got=%h exp=%h", got_q[895], mk(6, 0, 253, 255, 127));
        end
        n_tests++;
        if ((done_q.size() > 0 ? done_q[0] : -1) !== 897) begin
            n_fail++;
            $display("FAIL fwd_done_cycle got=%0d exp=897", done_q.size() > 0 ? done_q[0] : -1);
        end
    endtask

    task automatic test_inverse();
        int bad;
        build_model(1'b1);
        drive(1'b1, 100, 1'b0, -1, -1, 1, 3000);
        n_tests++;
        if (got_q.size() !== 1152) begin
            n_fail++;
            $display("FAIL inv_count got=%0d exp=1152", got_q.size());
        end
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL inv_seq idx=%0d got=%h exp=%h", bad, got_q[bad], exp_q[bad]);
        end
        n_tests++;
        if (got_q[0] !== mk(0, 0, 0, 2, 127) || got_q[1] !== mk(0, 0, 1, 3, 127) ||
            got_q[2] !== mk(0, 0, 4, 6, 126)) begin
            n_fail++;
            $display("FAIL inv_first got=%h,%h,%h exp=%h,%h,%h", got_q[0], got_q[1], got_q[2],
                     mk(0, 0, 0, 2, 127), mk(0, 0, 1, 3, 127), mk(0, 0, 4, 6, 126));
        end
        n_tests++;
        if (got_q[895] !== mk(6, 0, 127, 255, 1)) begin
            n_fail++;
            $display("FAIL inv_last_bf got=%h exp=%h", got_q[895], mk(6, 0, 127, 255, 1));
        end
        n_tests++;
        if (got_q[896] !== mk(6, 1, 0, 0, 0) || got_q[1151] !== mk(6, 1, 255, 0, 0)) begin
            n_fail++;
            $display("FAIL inv_scale_ends got=%h,%h exp=%h,%h", got_q[896], got_q[1151],
                     mk(6, 1, 0, 0, 0), mk(6, 1, 255, 0, 0));
        end
        n_tests++;
        if ((done_q.size() > 0 ? done_q[0] : -1) !== 1153) begin
            n_fail++;
            $display("FAIL inv_done_cycle got=%0d exp=1153", done_q.size() > 0 ? done_q[0] : -1);
        end
    endtask

    task automatic test_random_ready();
        int bad;
        for (int m = 0; m < 2; m++) begin
            build_model(1'(m));
            drive(1'(m), 50, 1'b0, -1, -1, 1, 8000);
            bad = -1;
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
            n_tests++;
            if (bad >= 0 || got_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rand_seq inv=%0d idx=%0d size got=%0d exp=%0d", m, bad,
                         got_q.size(), exp_q.size());
            end
            n_tests++;
            if (stall_bad !== 0) begin
                n_fail++;
                $display("FAIL rand_stall_hold inv=%0d got=%0d changes exp=0", m, stall_bad);
            end
            n_tests++;
            if (done_q.size() !== 1) begin
                n_fail++;
                $display("FAIL rand_done inv=%0d got=%0d pulses exp=1", m, done_q.size());
            end
        end
    endtask

    task automatic test_start_ignored();
        int bad;
        build_model(1'b0);
        drive(1'b0, 100, 1'b0, 10, -1, 1, 3000);
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        n_tests++;
        if (bad >= 0 || got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL busy_start_seq idx=%0d size got=%0d exp=%0d", bad, got_q.size(), exp_q.size());
        end
        n_tests++;
        if ((done_q.size() > 0 ? done_q[0] : -1) !== 897) begin
            n_fail++;
            $display("FAIL busy_start_done got=%0d exp=897", done_q.size() > 0 ? done_q[0] : -1);
        end
    endtask

    task automatic test_reset_abort();
        logic [30:0] outs;
        int          act;
        int          bad;
        build_model(1'b0);
        drive(1'b0, 100, 1'b0, -1, 400, 1, 3000);
        n_tests++;
        if (got_q.size() !== 400) begin
            n_fail++;
            $display("FAIL abort_reach got=%0d exp=400", got_q.size());
        end
        #2 rst = 1'b1;
        #1;
        outs = {bf_valid, busy, done, scale, addr_a, addr_b, zeta_idx, layer};
        n_tests++;
        if (outs !== 31'd0) begin
            n_fail++;
            $display("FAIL abort_outputs got=%h exp=0", outs);
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        act = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bf_valid || busy || done) act++;
        end
        n_tests++;
        if (act !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet got=%0d active cycles exp=0", act);
        end
        drive(1'b0, 100, 1'b0, -1, -1, 1, 3000);
        n_tests++;
        if (got_q[0] !== mk(0, 0, 0, 128, 1)) begin
            n_fail++;
            $display("FAIL abort_replay_first got=%h exp=%h", got_q[0], mk(0, 0, 0, 128, 1));
        end
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        n_tests++;
        if (bad >= 0 || got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL abort_replay_seq idx=%0d size got=%0d exp=%0d", bad, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        cmd_t one[$];
        int   bad;
        int   gap_bad;
        build_model(1'b0);
        one = exp_q;
        for (int r = 1; r < 3; r++) foreach (one[i]) exp_q.push_back(one[i]);
        drive(1'b0, 100, 1'b1, -1, -1, 3, 4000);
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        n_tests++;
        if (bad >= 0 || got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_seq idx=%0d size got=%0d exp=%0d", bad, got_q.size(), exp_q.size());
        end
        n_tests++;
        if (done_q.size() !== 3) begin
            n_fail++;
            $display("FAIL b2b_done_count got=%0d exp=3", done_q.size());
        end
        // Each rerun costs the transfers plus the DONE and IDLE cycles.
        gap_bad = 0;
        for (int i = 0; i < done_q.size(); i++)
            if (done_q[i] !== 897 + i * (896 + 2)) gap_bad++;
        n_tests++;
        if (gap_bad !== 0 || done_q.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_period got first=%0d bad=%0d exp first=897 period=898",
                     done_q.size() > 0 ? done_q[0] : -1, gap_bad);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_random_ready();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
